tmds_decoder: RTL and testbench



---
 rtl/tmds_decoder.sv | 166 ++++++++++++++++
 tb/tb_tmds_decoder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_decoder.sv
// Receive-side TMDS channel decoder: finds the word boundary by watching for runs of
// control tokens, pulses bitslip while searching, and decodes symbols once locked.
module tmds_decoder #(
    parameter int CTRL_RUN       = 8,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int SLIP_WAIT      = 16,
    parameter int LOCK_TIMEOUT   = 8192
) (
    input  logic       clk_pix,
    input  logic       rst_pix,
    input  logic [9:0] tmds_in,
    output logic       bitslip,
    output logic       aligned,
    output logic       de,
    output logic [1:0] ctrl,
    output logic [7:0] dout
);

    localparam int RUN_W = $clog2(CTRL_RUN) + 1;
    localparam int ST_W  = $clog2(SEARCH_TIMEOUT) + 1;
    localparam int WT_W  = $clog2(SLIP_WAIT) + 1;
    localparam int LT_W  = $clog2(LOCK_TIMEOUT) + 1;
    localparam int TMR_A = (ST_W > WT_W) ? ST_W : WT_W;
    localparam int TMR_W = (TMR_A > LT_W) ? TMR_A : LT_W;

    localparam logic [RUN_W-1:0] RUN_MAX     = RUN_W'(CTRL_RUN);
    localparam logic [TMR_W-1:0] SEARCH_LAST = TMR_W'(SEARCH_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] WAIT_LAST   = TMR_W'(SLIP_WAIT - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST   = TMR_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_SEARCH,
        S_SLIP,
        S_WAIT,
        S_LOCKED
    } state_e;

    state_e             state_q, state_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               de_q, de_d;
    logic [1:0]         ctrl_q, ctrl_d;
    logic [7:0]         dout_q, dout_d;

    logic               is_ctrl;
    logic [1:0]         tok_val;
    logic [7:0]         q_sym;
    logic [7:0]         data_dec;
    logic [RUN_W-1:0]   run_nxt;
    logic               qualify;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        is_ctrl = 1'b1;
        tok_val = 2'b00;
        case (tmds_in)
            10'b1101010100: tok_val = 2'b00;
            10'b0010101011: tok_val = 2'b01;
            10'b0101010100: tok_val = 2'b10;
            10'b1010101011: tok_val = 2'b11;
            default:        is_ctrl = 1'b0;
        endcase
    end

    always_comb begin
        q_sym       = tmds_in[9] ? ~tmds_in[7:0] : tmds_in[7:0];
        data_dec    = 8'h00;
        data_dec[0] = q_sym[0];
        for (int i = 1; i < 8; i++) begin
            data_dec[i] = tmds_in[8] ? (q_sym[i] ^ q_sym[i-1]) : ~(q_sym[i] ^ q_sym[i-1]);
        end
    end

    // Run length of consecutive control tokens, saturating so a long blanking period stays qualified.
    always_comb begin
        run_nxt = '0;
        if (is_ctrl) begin
            run_nxt = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
        end
        qualify = (run_nxt == RUN_MAX);
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_nxt;
        timer_d = timer_q + 1'b1;
        case (state_q)
            S_SEARCH: begin
                if (qualify) begin
                    state_d = S_LOCKED;
                    timer_d = '0;
                end else if (timer_q == SEARCH_LAST) begin
                    state_d = S_SLIP;
                    timer_d = '0;
                end
            end
            S_SLIP: begin
                state_d = S_WAIT;
                run_d   = '0;
                timer_d = '0;
            end
            S_WAIT: begin
                // Deserializer output is unreliable while it settles; no run may build up.
                run_d = '0;
                if (timer_q == WAIT_LAST) begin
                    state_d = S_SEARCH;
                    timer_d = '0;
                end
            end
            S_LOCKED: begin
                if (qualify) begin
                    timer_d = '0;
                end else if (timer_q == LOCK_LAST) begin
                    state_d = S_SEARCH;
                    timer_d = '0;
                    run_d   = '0;
                end
            end
            default: begin
                state_d = S_SEARCH;
                run_d   = '0;
                timer_d = '0;
            end
        endcase
    end

    always_comb begin
        de_d   = 1'b0;
        dout_d = 8'h00;
        ctrl_d = ctrl_q;
        if (state_q == S_LOCKED) begin
            if (is_ctrl) begin
                ctrl_d = tok_val;
            end else begin
                de_d   = 1'b1;
                dout_d = data_dec;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            state_q <= S_SEARCH;
            run_q   <= '0;
            timer_q <= '0;
            de_q    <= 1'b0;
            ctrl_q  <= 2'b00;
            dout_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            timer_q <= timer_d;
            de_q    <= de_d;
            ctrl_q  <= ctrl_d;
            dout_q  <= dout_d;
        end
    end

    assign bitslip = (state_q == S_SLIP);
    assign aligned = (state_q == S_LOCKED);
    assign de      = de_q;
    assign ctrl    = ctrl_q;
    assign dout    = dout_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// Self-checking bench for tmds_decoder: directed lock/decode/slip scenarios plus a
// randomized locked-mode stream checked against a behavioural decode model.
module tb_tmds_decoder;

    localparam int CTRL_RUN       = 8;
    localparam int SEARCH_TIMEOUT = 64;
    localparam int SLIP_WAIT      = 16;
    localparam int LOCK_TIMEOUT   = 256;

    localparam logic [9:0] TOKENS [4] = '{10'b1101010100, 10'b0010101011,
                                          10'b0101010100, 10'b1010101011};

    logic       clk_pix = 1'b0;
    logic       rst_pix = 1'b0;
    logic [9:0] tmds_in = 10'd0;
    logic       bitslip;
    logic       aligned;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] dout;

    int         checks   = 0;
    int         failures = 0;
    logic [1:0] exp_ctrl = 2'b00;

    tmds_decoder #(
        .CTRL_RUN      (CTRL_RUN),
        .SEARCH_TIMEOUT(SEARCH_TIMEOUT),
        .SLIP_WAIT     (SLIP_WAIT),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT)
    ) dut (
        .clk_pix(clk_pix),
        .rst_pix(rst_pix),
        .tmds_in(tmds_in),
        .bitslip(bitslip),
        .aligned(aligned),
        .de     (de),
        .ctrl   (ctrl),
        .dout   (dout)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns the token's control value, or -1 for a data symbol.
    function automatic int token_value(input logic [9:0] s);
        for (int k = 0; k < 4; k++) begin
            if (s == TOKENS[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [7:0] ref_decode(input logic [9:0] s);
        logic [7:0] q;
        q = s[7:0] ^ {8{s[9]}};
        return q ^ (q << 1) ^ (s[8] ? 8'h00 : 8'hFE);
    endfunction

    function automatic logic [9:0] random_data();
        logic [9:0] s;
        do s = 10'($urandom); while (token_value(s) >= 0);
        return s;
    endfunction

    // Word seen by a deserializer whose boundary sits o bits into the repeating symbol.
    function automatic logic [9:0] rotate_word(input logic [9:0] w, input int o);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = w[(o + i) % 10];
        return r;
    endfunction

    task automatic tick(input logic [9:0] s);
        tmds_in = s;
        @(posedge clk_pix);
        #1;
    endtask

    task automatic apply_reset(input int cycles);
        rst_pix = 1'b1;
        repeat (cycles) tick(random_data());
        rst_pix  = 1'b0;
        exp_ctrl = 2'b00;
    endtask

    task automatic send_locked(input logic [9:0] s, input string tag);
        int         t;
        logic       exp_de;
        logic [7:0] exp_dout;
        tick(s);
        t = token_value(s);
        if (t >= 0) begin
            exp_ctrl = 2'(t);
            exp_de   = 1'b0;
            exp_dout = 8'h00;
        end else begin
            exp_de   = 1'b1;
            exp_dout = ref_decode(s);
        end
        check({tag, "_out"}, {21'd0, de, ctrl, dout}, {21'd0, exp_de, exp_ctrl, exp_dout});
        check({tag, "_aligned"}, aligned, 1'b1);
        check({tag, "_bitslip"}, bitslip, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int k;
        int offset;
        int pulses;
        int last_pulse;
        bit got_lock;

        // Reset: outputs idle on every reset cycle.
        rst_pix = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(random_data());
            check("reset_bitslip", bitslip, 1'b0);
            check("reset_aligned", aligned, 1'b0);
            check("reset_out", {de, ctrl, dout}, 11'd0);
        end
        rst_pix = 1'b0;

        // Lock on 8 tokens, aligned one cycle after the 8th.
        for (int i = 0; i < 8; i++) begin
            tick(TOKENS[0]);
            check("lock_aligned", aligned, (i == 7));
            check("lock_bitslip", bitslip, 1'b0);
        end
        check("lock_out", {de, ctrl, dout}, 11'd0);

        // Directed decode.
        send_locked(10'b0100000000, "dec_a");
        send_locked(10'b0111111111, "dec_b");
        send_locked(10'b1010101011, "dec_tok11");
        send_locked(random_data(), "dec_hold");
        check("dec_hold_ctrl", ctrl, 2'b11);

        // Randomized locked traffic with periodic blanking bursts.
        for (int seg = 0; seg < 4; seg++) begin
            int len;
            len = $urandom_range(30, 150);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 3) == 0) send_locked(TOKENS[$urandom_range(0, 3)], "rand_sym");
                else                           send_locked(10'($urandom), "rand_sym");
            end
            len = $urandom_range(8, 12);
            for (int j = 0; j < len; j++) send_locked(TOKENS[$urandom_range(0, 3)], "rand_blank");
        end

        // Lock loss after LOCK_TIMEOUT data-only cycles.
        send_locked(TOKENS[3], "loss_tok");
        for (int n = 1; n <= LOCK_TIMEOUT; n++) begin
            tick(random_data());
            check("loss_aligned", aligned, (n < LOCK_TIMEOUT));
            check("loss_bitslip", bitslip, 1'b0);
        end
        check("loss_last_de", de, 1'b1);
        tick(random_data());
        check("loss_de_next", de, 1'b0);
        check("loss_ctrl_hold", ctrl, 2'b11);

        // Search timeout after lock loss, then reset on the SLIP cycle.
        k = 0;
        while (!bitslip && k < 200) begin
            tick(random_data());
            k++;
        end
        check("search_timeout_cycles", k, SEARCH_TIMEOUT - 1);
        rst_pix = 1'b1;
        tick(random_data());
        rst_pix  = 1'b0;
        exp_ctrl = 2'b00;
        check("midslip_bitslip", bitslip, 1'b0);
        check("midslip_aligned", aligned, 1'b0);
        check("midslip_out", {de, ctrl, dout}, 11'd0);
        k = 0;
        while (!bitslip && k < 200) begin
            tick(random_data());
            k++;
        end
        check("midslip_timer_restart", k, SEARCH_TIMEOUT);

        // Run interruption: 7 tokens, data, 7 tokens stays unaligned; one more locks.
        apply_reset(2);
        for (int i = 0; i < 7; i++) begin
            tick(TOKENS[$urandom_range(0, 3)]);
            check("run_a_aligned", aligned, 1'b0);
        end
        tick(random_data());
        check("run_data_aligned", aligned, 1'b0);
        for (int i = 0; i < 7; i++) begin
            tick(TOKENS[$urandom_range(0, 3)]);
            check("run_b_aligned", aligned, 1'b0);
        end
        tick(TOKENS[$urandom_range(0, 3)]);
        check("run_final_aligned", aligned, 1'b1);
        check("run_final_out", {de, ctrl, dout}, 11'd0);

        // Misaligned stream: boundary three slips away from the token boundary.
        apply_reset(2);
        offset     = 7;
        pulses     = 0;
        last_pulse = -1000;
        got_lock   = 1'b0;
        for (int c = 0; c < 3000 && !got_lock; c++) begin
            tick(rotate_word(TOKENS[0], offset));
            if (bitslip) begin
                if (pulses > 0) check("slip_quiet_gap", (c - last_pulse - 1) >= SLIP_WAIT, 1'b1);
                pulses++;
                last_pulse = c;
                offset     = (offset + 1) % 10;
            end
            if (aligned) begin
                got_lock = 1'b1;
                check("slip_quiet_before_lock", (c - last_pulse - 1) >= SLIP_WAIT, 1'b1);
            end
        end
        check("slip_locked", got_lock, 1'b1);
        check("slip_pulses", pulses, 3);
        check("slip_offset", offset, 0);
        send_locked(random_data(), "slip_post_data");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
